// File: rtl/banco_registradores_param.sv
// Parametrised 2-read/1-write register bank with x0 hardwired to zero,
// a reset-driven one-register-per-cycle clear sequence and write-first read bypass.
module banco_registradores_param #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int INIT_IDX = 2,
    parameter logic [WIDTH-1:0] INIT_VAL = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reg_escrita,
    input  logic [ADDR_W-1:0] endereco_regd,
    input  logic [WIDTH-1:0]  dado_escrita,
    input  logic [ADDR_W-1:0] endereco_reg1,
    input  logic [ADDR_W-1:0] endereco_reg2,
    output logic [WIDTH-1:0]  valor_reg1,
    output logic [WIDTH-1:0]  valor_reg2,
    output logic              pronto
);

    typedef enum logic {LIMPANDO, PRONTO} estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] contador;
    logic [WIDTH-1:0]  registradores [NREGS];

    logic [1:0][ADDR_W-1:0] end_leitura;
    logic [1:0][WIDTH-1:0]  leitura;

    // Storage is deliberately not cleared on the reset edge; the clear walk reloads it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= LIMPANDO;
            contador <= '0;
            pronto   <= 1'b0;
        end else begin
            case (estado)
                LIMPANDO: begin
                    registradores[contador] <= (contador == ADDR_W'(INIT_IDX)) ? INIT_VAL : '0;
                    contador <= contador + 1'b1;
                    if (contador == ADDR_W'(NREGS - 1)) begin
                        estado <= PRONTO;
                        pronto <= 1'b1;
                    end
                end
                PRONTO: begin
                    if (pronto && reg_escrita && endereco_regd != '0)
                        registradores[endereco_regd] <= dado_escrita;
                end
                default: estado <= LIMPANDO;
            endcase
        end
    end

    assign end_leitura = {endereco_reg2, endereco_reg1};

    // Both ports bypass independently so decode sees a same-cycle writeback.
    always_comb begin
        leitura = '0;
        for (int k = 0; k < 2; k++) begin
            if (pronto && end_leitura[k] != '0) begin
                if (reg_escrita && endereco_regd == end_leitura[k])
                    leitura[k] = dado_escrita;
                else
                    leitura[k] = registradores[end_leitura[k]];
            end
        end
    end

    assign valor_reg1 = leitura[0];
    assign valor_reg2 = leitura[1];

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench for banco_registradores_param: default 32x32 instance plus a 16-bit x 8 instance.
module tb_banco_registradores_param;

    logic        clock;
    logic        reset, reg_escrita;
    logic [4:0]  endereco_regd, endereco_reg1, endereco_reg2;
    logic [31:0] dado_escrita, valor_reg1, valor_reg2;
    logic        pronto;

    logic        s_reset, s_reg_escrita;
    logic [2:0]  s_regd, s_reg1, s_reg2;
    logic [15:0] s_dado, s_v1, s_v2;
    logic        s_pronto;

    int checks = 0;
    int errors = 0;

    banco_registradores_param dut (
        .clock(clock), .reset(reset), .reg_escrita(reg_escrita),
        .endereco_regd(endereco_regd), .dado_escrita(dado_escrita),
        .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
        .valor_reg1(valor_reg1), .valor_reg2(valor_reg2), .pronto(pronto)
    );

    banco_registradores_param #(.WIDTH(16), .NREGS(8), .INIT_IDX(3), .INIT_VAL(16'h00FF)) dut_s (
        .clock(clock), .reset(s_reset), .reg_escrita(s_reg_escrita),
        .endereco_regd(s_regd), .dado_escrita(s_dado),
        .endereco_reg1(s_reg1), .endereco_reg2(s_reg2),
        .valor_reg1(s_v1), .valor_reg2(s_v2), .pronto(s_pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; reg_escrita = 1'b0; endereco_regd = '0; dado_escrita = '0;
        endereco_reg1 = 5'd2; endereco_reg2 = 5'd7;
        s_reset = 1'b1; s_reg_escrita = 1'b0; s_regd = '0; s_dado = '0; s_reg1 = '0; s_reg2 = '0;

        tick();
        chk("reset_pronto", {31'b0, pronto}, 32'd0);
        chk("reset_v1", valor_reg1, 32'd0);
        chk("reset_v2", valor_reg2, 32'd0);

        // Clear walk with a write to x7 held throughout; it must be dropped.
        reset = 1'b0; reg_escrita = 1'b1; endereco_regd = 5'd7; dado_escrita = 32'hA5A5A5A5;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk($sformatf("clear_pronto_e%0d", i), {31'b0, pronto}, 32'd0);
            if (i == 20) begin
                chk("clear_read_v1", valor_reg1, 32'd0);
                chk("clear_read_v2", valor_reg2, 32'd0);
            end
        end
        tick();
        chk("pronto_e32", {31'b0, pronto}, 32'd1);
        reg_escrita = 1'b0; #1;
        chk("x2_init", valor_reg1, 32'd1);
        chk("x7_dropped", valor_reg2, 32'd0);
        endereco_reg1 = 5'd1; endereco_reg2 = 5'd31; #1;
        chk("x1_zero", valor_reg1, 32'd0);
        chk("x31_zero", valor_reg2, 32'd0);

        // Write-first bypass then stored value.
        reg_escrita = 1'b1; endereco_regd = 5'd5; dado_escrita = 32'hDEADBEEF;
        endereco_reg1 = 5'd5; endereco_reg2 = 5'd2; #1;
        chk("x5_bypass", valor_reg1, 32'hDEADBEEF);
        chk("x2_no_bypass", valor_reg2, 32'd1);
        tick();
        reg_escrita = 1'b0; #1;
        chk("x5_stored", valor_reg1, 32'hDEADBEEF);

        // Both ports bypassing the same register.
        reg_escrita = 1'b1; dado_escrita = 32'h11111111; endereco_reg2 = 5'd5; #1;
        chk("dual_bypass_v1", valor_reg1, 32'h11111111);
        chk("dual_bypass_v2", valor_reg2, 32'h11111111);
        reg_escrita = 1'b0; #1;

        // Write to x0 is dropped and never bypassed.
        reg_escrita = 1'b1; endereco_regd = 5'd0; dado_escrita = 32'h00001234;
        endereco_reg1 = 5'd0; endereco_reg2 = 5'd0; #1;
        chk("x0_bypass_v1", valor_reg1, 32'd0);
        chk("x0_bypass_v2", valor_reg2, 32'd0);
        tick();
        reg_escrita = 1'b0; #1;
        chk("x0_after_v1", valor_reg1, 32'd0);
        chk("x0_after_v2", valor_reg2, 32'd0);

        // x9 write, reset, abort clear at cycle 10, full redo.
        reg_escrita = 1'b1; endereco_regd = 5'd9; dado_escrita = 32'h55;
        tick();
        reg_escrita = 1'b0; endereco_reg1 = 5'd9; endereco_reg2 = 5'd5; #1;
        chk("x9_stored", valor_reg1, 32'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_pronto", {31'b0, pronto}, 32'd0);
        chk("rst2_read", valor_reg1, 32'd0);
        for (int i = 1; i <= 9; i++) tick();
        chk("clear2_c9_pronto", {31'b0, pronto}, 32'd0);
        reg_escrita = 1'b1; endereco_regd = 5'd9; dado_escrita = 32'h77;
        reset = 1'b1;
        tick();
        reset = 1'b0; reg_escrita = 1'b0;
        for (int i = 1; i <= 31; i++) tick();
        chk("clear3_e31_pronto", {31'b0, pronto}, 32'd0);
        tick();
        chk("clear3_e32_pronto", {31'b0, pronto}, 32'd1);
        chk("x9_wiped", valor_reg1, 32'd0);
        chk("x5_wiped", valor_reg2, 32'd0);
        endereco_reg1 = 5'd2; #1;
        chk("x2_reinit", valor_reg1, 32'd1);

        // Small instance: 16-bit x 8 registers.
        s_reset = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        chk("s_e7_pronto", {31'b0, s_pronto}, 32'd0);
        tick();
        chk("s_e8_pronto", {31'b0, s_pronto}, 32'd1);
        s_reg1 = 3'd3; s_reg2 = 3'd2; #1;
        chk("s_x3_init", {16'b0, s_v1}, 32'h00FF);
        chk("s_x2_zero", {16'b0, s_v2}, 32'd0);
        s_reg_escrita = 1'b1; s_regd = 3'd7; s_dado = 16'hBEEF;
        tick();
        s_reg_escrita = 1'b0; s_reg1 = 3'd7; s_reg2 = 3'd0; #1;
        chk("s_x7_stored", {16'b0, s_v1}, 32'hBEEF);
        chk("s_x0_zero", {16'b0, s_v2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
